// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: hazard sources from ID/EXE/MEM,
// memory handshake, and the stall/flush pins back to the stage registers.
interface pipeline_hazard_ctrl_if;
  // ID operands
  logic [3:0]  id_src1;
  logic [3:0]  id_src2;
  logic        id_src1_used;
  logic        id_src2_used;
  // EXE / MEM producers
  logic [3:0]  exe_dest;
  logic        exe_wb_en;
  logic        exe_mem_read;
  logic [3:0]  mem_dest;
  logic        mem_wb_en;
  logic        branch_taken;
  // data memory handshake
  logic        mem_access;
  logic        mem_ready;
  // stage register control
  logic        pc_en;
  logic        if_id_en;
  logic        if_id_clr;
  logic        id_ex_en;
  logic        id_ex_clr;
  logic        ex_mem_en;
  logic        mem_wb_en_o;
  logic        mem_start;
  logic        mem_timeout;
  logic [15:0] stall_count;

  // pipeline side: drives hazard info, receives control
  modport master (
    output id_src1, id_src2, id_src1_used, id_src2_used,
           exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
           branch_taken, mem_access, mem_ready,
    input  pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr, ex_mem_en,
           mem_wb_en_o, mem_start, mem_timeout, stall_count
  );

  // controller side
  modport slave (
    input  id_src1, id_src2, id_src1_used, id_src2_used,
           exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
           branch_taken, mem_access, mem_ready,
    output pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr, ex_mem_en,
           mem_wb_en_o, mem_start, mem_timeout, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: RAW bubble insertion,
// branch flush, full freeze during multi-cycle data-memory accesses,
// memory watchdog and saturating stall counter.
module pipeline_hazard_ctrl #(
  parameter bit         FORWARD_EN = 1'b1,
  parameter logic [7:0] TIMEOUT    = 8'd255
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int NSRC = 2;

  typedef enum logic [1:0] {RUN, WAIT, DONE} state_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_clr;
    logic id_ex_en;
    logic id_ex_clr;
    logic ex_mem_en;
    logic mem_wb_en;
    logic mem_start;
  } ctl_t;

  state_t                       state, state_nxt;
  logic [7:0]                   wcnt;
  logic [15:0]                  stall_q;
  logic                         timeout_q;
  logic [NSRC-1:0][3:0]         src;
  logic [NSRC-1:0]              used;
  logic [NSRC-1:0]              hit_exe, hit_mem;
  logic                         hazard;
  logic                         use_normal;
  logic                         timeout_hit;
  ctl_t                         norm_ctl, fsm_ctl, ctl;

  assign src  = {bus.id_src2, bus.id_src1};
  assign used = {bus.id_src2_used, bus.id_src1_used};

  // per-operand dependency compares against the EXE and MEM producers
  always_comb begin
    hit_exe = '0;
    hit_mem = '0;
    for (int i = 0; i < NSRC; i++) begin
      hit_exe[i] = used[i] & (src[i] == bus.exe_dest) & bus.exe_wb_en;
      hit_mem[i] = used[i] & (src[i] == bus.mem_dest) & bus.mem_wb_en;
    end
  end

  // with forwarding only a load in EXE cannot be bypassed in time
  assign hazard = FORWARD_EN ? (bus.exe_mem_read & (|hit_exe))
                             : ((|hit_exe) | (|hit_mem));

  // normal control: branch flush beats the bubble, since the hazarding
  // instruction in ID is being flushed anyway
  always_comb begin
    norm_ctl = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_clr: 1'b0,
                 id_ex_en: 1'b1, id_ex_clr: 1'b0, ex_mem_en: 1'b1,
                 mem_wb_en: 1'b1, mem_start: 1'b0};
    if (bus.branch_taken) begin
      norm_ctl.if_id_clr = 1'b1;
      norm_ctl.id_ex_clr = 1'b1;
    end else if (hazard) begin
      norm_ctl.pc_en     = 1'b0;
      norm_ctl.if_id_en  = 1'b0;
      norm_ctl.id_ex_clr = 1'b1;
    end
  end

  // watchdog fires only when the wait budget is spent without a ready
  assign timeout_hit = (state == WAIT) & ~bus.mem_ready & (wcnt == TIMEOUT);

  // next state and freeze control; RUN/DONE defer to normal control
  always_comb begin
    state_nxt  = state;
    fsm_ctl    = '0;
    use_normal = 1'b0;
    unique case (state)
      RUN: begin
        if (bus.mem_access) begin
          fsm_ctl.mem_start = 1'b1;
          state_nxt         = WAIT;
        end else begin
          use_normal = 1'b1;
        end
      end
      WAIT: begin
        if (bus.mem_ready || timeout_hit) state_nxt = DONE;
      end
      DONE: begin
        // the memory instruction retires now; mem_access is stale
        use_normal = 1'b1;
        state_nxt  = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // reset forces every enable, clear and mem_start low
  assign ctl = !rst ? '0 : (use_normal ? norm_ctl : fsm_ctl);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  // wait counter: 1 in the first WAIT cycle, counting up while waiting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  wcnt <= '0;
    else if (state == RUN && bus.mem_access)   wcnt <= 8'd1;
    else if (state == WAIT)                    wcnt <= wcnt + 8'd1;
  end

  // sticky watchdog flag, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             timeout_q <= 1'b0;
    else if (timeout_hit) timeout_q <= 1'b1;
  end

  // saturating count of cycles the PC was held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                stall_q <= '0;
    else if (!ctl.pc_en && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end

  assign bus.pc_en       = ctl.pc_en;
  assign bus.if_id_en    = ctl.if_id_en;
  assign bus.if_id_clr   = ctl.if_id_clr;
  assign bus.id_ex_en    = ctl.id_ex_en;
  assign bus.id_ex_clr   = ctl.id_ex_clr;
  assign bus.ex_mem_en   = ctl.ex_mem_en;
  assign bus.mem_wb_en_o = ctl.mem_wb_en;
  assign bus.mem_start   = ctl.mem_start;
  assign bus.mem_timeout = timeout_q;
  assign bus.stall_count = stall_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage ARM pipeline (IF, ID, EXE, MEM, WB).
- Drives the PC enable and the enable/clear pins of the IF/ID, ID/EXE, EXE/MEM and MEM/WB stage registers.
- Detects RAW hazards in ID, flushes younger stages on a taken branch, and freezes the whole pipeline while a multi-cycle data-memory access completes.
- Provides a memory timeout watchdog and a stall performance counter.

Parameters:
FORWARD_EN, 1, 1 = forwarding present, stall only on load-use; 0 = stall on any RAW hit against EXE or MEM
TIMEOUT, 255, maximum WAIT cycles before an access is abandoned (8-bit counter, 1..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
id_src1  in  4  ID source register 1
id_src2  in  4  ID source register 2
id_src1_used  in  1  src1 is read by the ID instruction
id_src2_used  in  1  src2 is read by the ID instruction
exe_dest  in  4  EXE destination register
exe_wb_en  in  1  EXE instruction writes back
exe_mem_read  in  1  EXE instruction is a load
mem_dest  in  4  MEM destination register
mem_wb_en  in  1  MEM instruction writes back
branch_taken  in  1  taken branch resolved in EXE
mem_access  in  1  MEM instruction is a load or store
mem_ready  in  1  data memory finished the access
pc_en  out  1  PC update enable
if_id_en, if_id_clr  out  1 each  IF/ID register enable / synchronous clear
id_ex_en, id_ex_clr  out  1 each  ID/EXE register enable / clear
ex_mem_en  out  1  EXE/MEM register enable
mem_wb_en_o  out  1  MEM/WB register enable
mem_start  out  1  one-cycle pulse that starts a data-memory access
mem_timeout  out  1  sticky flag: an access exceeded TIMEOUT
stall_count  out  16  saturating count of cycles with pc_en = 0

Behaviour:
- Reset: rst = 0 acts asynchronously. State goes to RUN; wait counter, stall_count and mem_timeout go to 0. While rst is low, all enables, clears and mem_start are forced to 0.
- States: RUN, WAIT, DONE.
- hit1 = id_src1_used & (id_src1 == exe_dest) & exe_wb_en. hit2 is the same with id_src2.
- FORWARD_EN = 1: hazard = exe_mem_read & (hit1 | hit2).
- FORWARD_EN = 0: hazard = hit1 | hit2 | the same compares against mem_dest / mem_wb_en.
- Normal control, used in RUN with no mem_access, and in DONE. Evaluate in this order; the first match applies:
  - branch_taken: all enables 1, if_id_clr = 1, id_ex_clr = 1. Branch wins over hazard because the hazarding instruction is flushed anyway.
  - hazard: pc_en = 0, if_id_en = 0, id_ex_clr = 1. All other enables 1, so a bubble is inserted.
  - otherwise: all enables 1, all clears 0.
- RUN with mem_access = 1:
  - Assert mem_start for this cycle and go to WAIT; wait counter loads 1.
  - All enables 0, all clears 0 (full freeze). branch_taken and hazard are ignored this cycle.
- WAIT:
  - All enables and clears are 0; mem_start = 0. Counter increments each cycle.
  - mem_ready = 1: go to DONE.
  - Else, if counter == TIMEOUT: set mem_timeout and go to DONE (access abandoned).
  - mem_ready is sampled only in WAIT. A mem_ready in the mem_start cycle is ignored.
- DONE:
  - Lasts exactly 1 cycle. Normal control applies; mem_access is ignored because the instruction it belongs to retires this cycle.
  - Next state is RUN. A back-to-back memory instruction is detected in RUN on the following cycle.
- A branch_taken that arrives during the freeze is held by the frozen EXE stage and acted on in DONE.
- stall_count increments on every clock edge where rst = 1 and pc_en = 0. It saturates at 0xFFFF.
- mem_timeout clears only on reset.
- Outputs are combinational from state and inputs. State, counter, stall_count and mem_timeout are registered.
- Reset asserted mid-WAIT: returns to RUN; no mem_start is emitted until rst is released.

Test Plan:
- FORWARD_EN = 1, load r3 in EXE (exe_mem_read = 1, exe_dest = 3, exe_wb_en = 1), ID reads r3 via src1 -> one cycle of pc_en = 0, if_id_en = 0, id_ex_clr = 1, stall_count = 1. Same case with exe_mem_read = 0 -> no stall.
- FORWARD_EN = 0, mem_dest = 5, mem_wb_en = 1, ID reads r5 via src2 -> stall asserted. Same with id_src2_used = 0 -> no stall.
- branch_taken = 1 together with an active hazard -> if_id_clr = 1, id_ex_clr = 1, pc_en = 1, no stall counted.
- mem_access = 1, mem_ready pulsed 3 cycles after mem_start -> mem_start high 1 cycle, then 3 WAIT cycles with all enables 0, then 1 DONE cycle with all enables 1, then RUN. stall_count = 4.
- TIMEOUT = 4, mem_ready never asserted -> 4 WAIT cycles, mem_timeout = 1 and stays set, then DONE, then RUN.
- rst driven low asynchronously mid-WAIT -> outputs 0 immediately. After release: state RUN, stall_count = 0, mem_timeout = 0.
